// File: rtl/usram_arb_pkg.sv
// Shared types and default sizes for the unified SRAM arbiter.
package usram_arb_pkg;

  localparam int AW_DEF       = 12;
  localparam int DW_DEF       = 64;
  localparam int MAX_WAIT_DEF = 16;

  typedef enum logic {OWN_SOC, OWN_ACC} owner_e;

  typedef enum logic {SHARED, ACC_OWN} arb_state_e;

endpackage

// File: rtl/usram_arbiter.sv
// Single-port SRAM arbiter between SoC port and MHSA accelerator: round-robin when idle, acc priority while busy.
// Latency: grant drives SRAM in the same cycle; read data returns with rvalid exactly one cycle after a read grant.
// Backpressure: losers see gnt=0 and must hold their request; USRAM_ARB_STARVE_EN bounds SoC wait under acc priority.
module usram_arbiter
  import usram_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_busy,
  input  logic          soc_req,
  input  logic          soc_we,
  input  logic [AW-1:0] soc_addr,
  input  logic [DW-1:0] soc_wdata,
  output logic          soc_gnt,
  output logic          soc_rvalid,
  output logic [DW-1:0] soc_rdata,
  input  logic          acc_req,
  input  logic          acc_we,
  input  logic [AW-1:0] acc_addr,
  input  logic [DW-1:0] acc_wdata,
  output logic          acc_gnt,
  output logic          acc_rvalid,
  output logic [DW-1:0] acc_rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  arb_state_e state;
  owner_e     last_win;
  owner_e     rd_owner;
  logic       rd_pend;
  logic       starve;

  always_comb begin
    soc_gnt = 1'b0;
    acc_gnt = 1'b0;
    if (!rst) begin
      if (soc_req && acc_req) begin
        if (state == ACC_OWN) begin
          soc_gnt = starve;
          acc_gnt = ~starve;
        end else if (last_win == OWN_SOC) begin
          acc_gnt = 1'b1;
        end else begin
          soc_gnt = 1'b1;
        end
      end else begin
        soc_gnt = soc_req;
        acc_gnt = acc_req;
      end
    end
  end

  assign sram_ce    = soc_gnt | acc_gnt;
  assign sram_we    = (acc_gnt & acc_we) | (soc_gnt & soc_we);
  assign sram_addr  = acc_gnt ? acc_addr  : soc_addr;
  assign sram_wdata = acc_gnt ? acc_wdata : soc_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SHARED;
      last_win <= OWN_SOC;
      rd_pend  <= 1'b0;
      rd_owner <= OWN_SOC;
    end else begin
      state   <= acc_busy ? ACC_OWN : SHARED;
      rd_pend <= sram_ce & ~sram_we;
      if (sram_ce) begin
        last_win <= acc_gnt ? OWN_ACC : OWN_SOC;
        rd_owner <= acc_gnt ? OWN_ACC : OWN_SOC;
      end
    end
  end

  // A reset arriving while a read is in flight must squash its response.
  assign soc_rvalid = rd_pend & ~rst & (rd_owner == OWN_SOC);
  assign acc_rvalid = rd_pend & ~rst & (rd_owner == OWN_ACC);
  assign soc_rdata  = sram_rdata;
  assign acc_rdata  = sram_rdata;

`ifdef USRAM_ARB_STARVE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != ACC_OWN || soc_gnt) begin
      wait_cnt <= '0;
    end else if (soc_req && wait_cnt != CW'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign starve = (wait_cnt == CW'(MAX_WAIT));
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
  assign starve = 1'b0;
`endif

endmodule
